// File: rtl/tfacc_rdarb_pkg.sv
// tfacc_rdarb_pkg: shared logic types and constants for the tfacc read-port
// arbiter and its round-robin picker.
//   u8_t/u24_t/u32_t/u64_t : plain unsigned vector types
//   BURST_BYTES            : bytes per read burst (address alignment unit)
//   RD_BEAT_W              : read data beat width in bits
//   GNT_W                  : width of grant indices (up to 8 requesters)
//   rd_state_t             : arbiter FSM state encoding
//   burst_align()          : clears the in-burst byte offset of an address
package tfacc_rdarb_pkg;

  localparam int BURST_BYTES = 1024;
  localparam int RD_BEAT_W   = 64;
  localparam int GNT_W       = 3;

  typedef logic [7:0]           u8_t;
  typedef logic [23:0]          u24_t;
  typedef logic [31:0]          u32_t;
  typedef logic [RD_BEAT_W-1:0] u64_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_t;

  function automatic u32_t burst_align(input u32_t a);
    return a & ~u32_t'(BURST_BYTES - 1);
  endfunction

endpackage

// File: rtl/tfacc_rdarb_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req   : request vector, one bit per requester
//   last  : index of the most recently served requester
//   found : at least one request is pending
//   idx   : first requester at or after (last+1) mod Np, wrapping
module rr_pick
  import tfacc_rdarb_pkg::*;
#(
  parameter int Np = 4
) (
  input  logic [Np-1:0]    req,
  input  logic [GNT_W-1:0] last,
  output logic             found,
  output logic [GNT_W-1:0] idx
);

  always_comb begin
    int unsigned w_j;
    found = 1'b0;
    idx   = '0;
    w_j   = 0;
    for (int k = 1; k <= Np; k++) begin
      w_j = (int'(last) + k) % Np;
      // Constant-index scan keeps the req select free of wide index math.
      for (int i = 0; i < Np; i++) begin
        if (!found && (w_j == i) && req[i]) begin
          found = 1'b1;
          idx   = GNT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/tfacc_rdarb.sv
// tfacc_rdarb: round-robin arbiter sharing one burst read master among Np
// input caches. Converts each cache's 24-bit offset into an absolute,
// burst-aligned 32-bit address and steers returned beats to the grantee.
//   aclk, arst          : clock, synchronous active-high reset
//   rbase               : feature-map base address, sampled at grant
//   rreq/radr           : per-cache burst request and start offset
//   rack/rdata          : per-cache beat strobe and (broadcast) beat data
//   m_req/m_ack/m_adr/m_len            : burst address handshake
//   m_rvalid/m_rdata/m_rlast           : returned data beats
//   busy, gnt_id, err   : status; err is sticky until arst
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no burst in flight; pick a winner and latch its address
// ADDR    | m_req held with the latched address until m_ack
// DATA    | counting BurstBeats beats, steering them to the grantee
module tfacc_rdarb
  import tfacc_rdarb_pkg::*;
#(
  parameter int Np         = 4,
  parameter int BurstBeats = 128
) (
  input  logic             aclk,
  input  logic             arst,
  input  u32_t             rbase,
  input  logic [Np-1:0]    rreq,
  input  u24_t             radr [Np],
  output logic [Np-1:0]    rack,
  output u64_t             rdata [Np],
  output logic             m_req,
  input  logic             m_ack,
  output u32_t             m_adr,
  output u8_t              m_len,
  input  logic             m_rvalid,
  input  u64_t             m_rdata,
  input  logic             m_rlast,
  output logic             busy,
  output logic [GNT_W-1:0] gnt_id,
  output logic             err
);

  localparam u8_t              LAST_BEAT = u8_t'(BurstBeats - 1);
  // Reset pointer at Np-1 so requester 0 is searched first.
  localparam logic [GNT_W-1:0] LAST_RST  = GNT_W'(Np - 1);

  rd_state_t        r_state;
  rd_state_t        w_state_nxt;
  logic [GNT_W-1:0] r_gnt;
  logic [GNT_W-1:0] r_last;
  u32_t             r_adr;
  u8_t              r_bcnt;
  logic             r_err;

  logic             w_found;
  logic [GNT_W-1:0] w_idx;
  u24_t             w_radr_sel;
  logic             w_last_beat;
  logic             w_beat;

  rr_pick #(.Np(Np)) u_rr_pick (
    .req   (rreq),
    .last  (r_last),
    .found (w_found),
    .idx   (w_idx)
  );

  always_comb begin
    w_radr_sel = '0;
    for (int i = 0; i < Np; i++) begin
      if (w_idx == GNT_W'(i)) w_radr_sel = radr[i];
    end
  end

  assign w_last_beat = (r_bcnt == LAST_BEAT);
  assign w_beat      = (r_state == ST_DATA) && m_rvalid;

  always_comb begin
    w_state_nxt = r_state;
    m_req       = 1'b0;
    case (r_state)
      ST_IDLE: if (w_found) w_state_nxt = ST_ADDR;
      ST_ADDR: begin
        m_req = 1'b1;
        if (m_ack) w_state_nxt = ST_DATA;
      end
      ST_DATA: if (m_rvalid && w_last_beat) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_gnt  <= '0;
      r_last <= LAST_RST;
      r_adr  <= '0;
      r_bcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_found) begin
        r_gnt <= w_idx;
        // 32-bit sum wraps by design; alignment applied after the add.
        r_adr <= burst_align(rbase + {8'h00, w_radr_sel});
      end
      if ((r_state == ST_ADDR) && m_ack) begin
        r_last <= r_gnt;
        r_bcnt <= '0;
      end
      if (w_beat) begin
        r_bcnt <= r_bcnt + 8'd1;
        if (m_rlast != w_last_beat) r_err <= 1'b1;
      end
    end
  end

  // Beats for a grantee that dropped its request are consumed silently.
  always_comb begin
    rack = '0;
    for (int i = 0; i < Np; i++) begin
      rack[i] = w_beat && (r_gnt == GNT_W'(i)) && rreq[i];
    end
  end

  always_comb begin
    for (int i = 0; i < Np; i++) rdata[i] = m_rdata;
  end

  assign m_adr  = r_adr;
  assign m_len  = LAST_BEAT;
  assign busy   = (r_state != ST_IDLE);
  assign gnt_id = r_gnt;
  assign err    = r_err;

endmodule

// File: tb/tb_tfacc_rdarb.sv
// tb_tfacc_rdarb: directed scenarios with randomized beat timing, data,
// addresses and ack delays, checked against a behavioural arbiter model.
module tb_tfacc_rdarb;

  localparam int NP = 4;
  localparam int BB = 128;

  logic        aclk = 1'b0;
  logic        arst;
  logic [31:0] rbase;
  logic [3:0]  rreq;
  logic [23:0] radr [NP];
  logic [3:0]  rack;
  logic [63:0] rdata [NP];
  logic        m_req;
  logic        m_ack;
  logic [31:0] m_adr;
  logic [7:0]  m_len;
  logic        m_rvalid;
  logic [63:0] m_rdata;
  logic        m_rlast;
  logic        busy;
  logic [2:0]  gnt_id;
  logic        err;

  tfacc_rdarb #(.Np(NP), .BurstBeats(BB)) dut (
    .aclk     (aclk),
    .arst     (arst),
    .rbase    (rbase),
    .rreq     (rreq),
    .radr     (radr),
    .rack     (rack),
    .rdata    (rdata),
    .m_req    (m_req),
    .m_ack    (m_ack),
    .m_adr    (m_adr),
    .m_len    (m_len),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .m_rlast  (m_rlast),
    .busy     (busy),
    .gnt_id   (gnt_id),
    .err      (err)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int mdl_last;
  bit exp_err;
  int last_id;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first requester found searching from last+1, wrapping.
  function automatic int pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= NP; k++) begin
      if (req[(last + k) % NP]) return (last + k) % NP;
    end
    return 0;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] b, input logic [23:0] o);
    logic [31:0] s;
    s = b + {8'h00, o};
    return s - (s % 32'd1024);
  endfunction

  task automatic check_reset_vals();
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_m_req",  64'(m_req),  64'd0);
    chk("rst_m_adr",  64'(m_adr),  64'd0);
    chk("rst_gnt_id", 64'(gnt_id), 64'd0);
    chk("rst_err",    64'(err),    64'd0);
    chk("rst_rack",   64'(rack),   64'd0);
  endtask

  // exp_wait: cycles from entry negedge to m_req (-1 = don't check).
  // drop_at/rlast_at/rst_at are beat counts; -1 disables each.
  task automatic run_burst(input int exp_wait, input logic [3:0] add_req, input int ack_delay,
                           input int drop_at, input int rlast_at, input int rst_at);
    int          id;
    int          waited;
    int          beat;
    int          cyc;
    int          pulses;
    logic [31:0] eadr;
    logic [3:0]  erack;
    id   = pick(rreq, mdl_last);
    eadr = exp_addr(rbase, radr[id]);
    waited = 0;
    @(negedge aclk);
    while (!m_req && waited < 10) begin
      waited++;
      @(negedge aclk);
    end
    if (exp_wait >= 0) chk("req_latency", 64'(waited), 64'(exp_wait));
    chk("gnt_id", 64'(gnt_id), 64'(id));
    chk("m_adr",  64'(m_adr),  64'(eadr));
    chk("m_len",  64'(m_len),  64'(BB - 1));
    chk("busy",   64'(busy),   64'd1);
    last_id  = int'(gnt_id);
    mdl_last = id;
    @(posedge aclk); #1;
    rreq  = rreq | add_req;
    rbase = $urandom;
    for (int c = 0; c < ack_delay; c++) begin
      @(negedge aclk);
      chk("m_req_hold", 64'(m_req), 64'd1);
      chk("m_adr_hold", 64'(m_adr), 64'(eadr));
      @(posedge aclk); #1;
    end
    m_ack = 1'b1;
    @(negedge aclk);
    chk("m_req_at_ack", 64'(m_req), 64'd1);
    @(posedge aclk); #1;
    m_ack  = 1'b0;
    beat   = 0;
    cyc    = 0;
    pulses = 0;
    while (beat < BB && cyc < 3000) begin
      if (beat == drop_at) rreq[id] = 1'b0;
      if (beat == rst_at) begin
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        arst     = 1'b1;
        @(posedge aclk); #1;
        arst = 1'b0;
        rreq = '0;
        @(negedge aclk);
        check_reset_vals();
        mdl_last = NP - 1;
        exp_err  = 1'b0;
        return;
      end
      m_rvalid = ($urandom_range(0, 3) != 0);
      m_rdata  = {$urandom, $urandom};
      m_rlast  = m_rvalid && ((rlast_at >= 0) ? (beat == rlast_at) : (beat == BB - 1));
      erack     = '0;
      erack[id] = m_rvalid && rreq[id];
      @(negedge aclk);
      chk("m_req_low", 64'(m_req), 64'd0);
      chk("rack",      64'(rack),  64'(erack));
      if (m_rvalid) begin
        chk("rdata", rdata[id], m_rdata);
        if (rack[id]) pulses++;
        beat++;
      end
      cyc++;
      @(posedge aclk); #1;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    chk("beat_count",  64'(beat),   64'(BB));
    chk("rack_pulses", 64'(pulses), 64'((drop_at >= 0) ? drop_at : BB));
    if (rlast_at >= 0 && rlast_at != BB - 1) exp_err = 1'b1;
    @(negedge aclk);
    chk("busy_after", 64'(busy),  64'd0);
    chk("req_gap",    64'(m_req), 64'd0);
    chk("err",        64'(err),   64'(exp_err));
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1;
    arst = 1'b1;
    @(posedge aclk); #1;
    arst = 1'b0;
    mdl_last = NP - 1;
    exp_err  = 1'b0;
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    arst = 1'b1; rbase = '0; rreq = '0; m_ack = 1'b0;
    m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
    for (int i = 0; i < NP; i++) radr[i] = '0;
    mdl_last = NP - 1;
    exp_err  = 1'b0;
    last_id  = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_reset_vals();
    @(posedge aclk); #1;
    arst = 1'b0;

    // Single requester on lane 2.
    rbase   = 32'h1000_0000;
    radr[2] = 24'h00_0400;
    rreq    = 4'b0100;
    run_burst(1, 4'b0000, 3, -1, -1, -1);
    chk("single_adr_id", 64'(last_id), 64'd2);
    rreq = '0;

    // Fairness with all lanes requesting continuously.
    pulse_reset();
    for (int i = 0; i < NP; i++) radr[i] = 24'($urandom);
    rbase = $urandom;
    rreq  = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      run_burst((n == 0) ? 1 : 0, 4'b0000, $urandom_range(0, 4), -1, -1, -1);
      chk("fair_order", 64'(last_id), 64'(order[n]));
    end
    rreq = '0;

    // Address alignment.
    @(posedge aclk); #1;
    rbase   = $urandom & 32'hFFFF_FC00;
    radr[1] = 24'h00_07FF;
    rreq    = 4'b0010;
    run_burst(1, 4'b0000, 1, -1, -1, -1);
    rreq = '0;

    // Drop mid-burst with lane 1 arriving meanwhile.
    pulse_reset();
    rbase   = $urandom;
    radr[0] = 24'($urandom);
    rreq    = 4'b0001;
    run_burst(1, 4'b0010, 2, 10, -1, -1);
    run_burst(0, 4'b0000, 0, -1, -1, -1);
    chk("drop_next", 64'(last_id), 64'd1);
    rreq = '0;

    // Early m_rlast, then a clean burst: err stays set.
    @(posedge aclk); #1;
    radr[3] = 24'($urandom);
    rreq    = 4'b1000;
    run_burst(1, 4'b0000, 1, -1, 64, -1);
    rreq = '0;
    @(posedge aclk); #1;
    rreq = 4'b0100;
    run_burst(1, 4'b0000, 0, -1, -1, -1);
    rreq = '0;

    // Long m_ack stall, then reset during Data.
    @(posedge aclk); #1;
    rreq = 4'b0100;
    run_burst(1, 4'b0000, 20, -1, -1, 40);

    // After reset, requester 0 wins first.
    @(posedge aclk); #1;
    rbase = $urandom;
    for (int i = 0; i < NP; i++) radr[i] = 24'($urandom);
    rreq = 4'b1111;
    run_burst(1, 4'b0000, 1, -1, -1, -1);
    chk("post_rst_first", 64'(last_id), 64'd0);
    rreq = '0;

    repeat (2) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
